bloom_block_access: RTL and testbench

Consumes one hash result per item from the bloom-filter hash pipeline and performs the filter access. The main hash selects one BLOCK_WIDTH-bit filter block in external memory, and the subsidiary hashes select bits inside that block. Query reports whether every selected bit is set. Insert performs read-modify-write to set them. Sits directly downstream of the hash pipeline and throttles it through `ready4_hash`.

---
 rtl/bloom_block_access.sv | 250 +++++++++++++++++++++++++
 tb/tb_bloom_block_access.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bloom_block_access.sv
// -----------------------------------------------------------------------------
// bloom_block_access
//
// Performs the filter access for one hashed item at a time. The main hash
// selects a BLOCK_WIDTH-bit block in external memory; each subsidiary hash
// selects one bit inside that block. A query reports whether every selected
// bit is already set. An insert also read-modify-writes the block so that
// those bits become set. The write is skipped when they were all set already.
//
// Only one item is in flight. ready4_hash is high only in IDLE, which stalls
// the upstream hash pipeline while an access is running.
//
// Ports
//   clk, rstb               clock; asynchronous active-low reset
//   hash_valid              hash word present (upstream already gated by ready4_hash)
//   main_hash               block address
//   subsidiary_hash_values  packed bit indices, index i at [i*SHW +: SHW]
//   insert_mode             1 = insert, 0 = query (sampled at capture)
//   ready4_hash             block accepts a hash word this cycle
//   mem_rd_req/mem_wr_req   memory read / write request (never both high)
//   mem_addr, mem_wr_data   request address and write data
//   mem_ready               memory accepts the current request
//   mem_rd_valid/_data      read return
//   result_valid/_hit       result handshake towards the consumer
//   result_ready            consumer takes the result
//   item_count, hit_count   wrapping 32-bit completion statistics
// -----------------------------------------------------------------------------
module bloom_block_access #(
  parameter int MAIN_HASH_WIDTH       = 30,
  parameter int SUBSIDIARY_HASH_WIDTH = 9,
  parameter int NUM_SUBSIDIARY_HASH   = 6,
  // Must equal 2**SUBSIDIARY_HASH_WIDTH so every index lands inside the block.
  parameter int BLOCK_WIDTH           = 512
) (
  input  logic                                             clk,
  input  logic                                             rstb,
  input  logic                                             hash_valid,
  input  logic [MAIN_HASH_WIDTH-1:0]                       main_hash,
  input  logic [NUM_SUBSIDIARY_HASH*SUBSIDIARY_HASH_WIDTH-1:0] subsidiary_hash_values,
  input  logic                                             insert_mode,
  output logic                                             ready4_hash,
  output logic                                             mem_rd_req,
  output logic                                             mem_wr_req,
  output logic [MAIN_HASH_WIDTH-1:0]                       mem_addr,
  output logic [BLOCK_WIDTH-1:0]                           mem_wr_data,
  input  logic                                             mem_ready,
  input  logic                                             mem_rd_valid,
  input  logic [BLOCK_WIDTH-1:0]                           mem_rd_data,
  output logic                                             result_valid,
  output logic                                             result_hit,
  input  logic                                             result_ready,
  output logic [31:0]                                      item_count,
  output logic [31:0]                                      hit_count
);

  localparam int SHW = SUBSIDIARY_HASH_WIDTH;
  localparam int NSH = NUM_SUBSIDIARY_HASH;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    CHECK,
    WR_REQ,
    RESP
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [MAIN_HASH_WIDTH-1:0] addr_reg;
  logic [BLOCK_WIDTH-1:0]     mask_reg;
  logic                       insert_reg;
  logic [BLOCK_WIDTH-1:0]     block_reg;
  logic [BLOCK_WIDTH-1:0]     new_block_reg;
  logic                       hit_reg;
  logic [31:0]                item_count_reg;
  logic [31:0]                hit_count_reg;

  // Handshake qualifiers, decoded once so the register blocks stay readable.
  logic capture;
  logic rd_data_take;
  logic resp_done;

  // ---------------------------------------------------------------------------
  // Index decode. Each subsidiary hash becomes a one-hot block-wide vector, and
  // the OR of all of them is the selection mask. Duplicate indices therefore
  // collapse into one mask bit. The mask is computed from the live input and
  // registered at capture. That is equivalent to capturing the raw indices, and
  // it keeps the wide decode out of the CHECK cycle.
  // ---------------------------------------------------------------------------
  logic [NSH-1:0][BLOCK_WIDTH-1:0] onehot;
  logic [BLOCK_WIDTH-1:0]          mask_in;

  for (genvar gi = 0; gi < NSH; gi++) begin : g_decode
    assign onehot[gi] = {{(BLOCK_WIDTH-1){1'b0}}, 1'b1}
                        << subsidiary_hash_values[gi*SHW +: SHW];
  end

  always_comb begin
    mask_in = '0;
    for (int i = 0; i < NSH; i++) begin
      mask_in = mask_in | onehot[i];
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs. Request outputs are pure decodes of the state and
  // of registers that only change at capture or in CHECK. They stay stable
  // while the block waits for mem_ready. Address and data are forced to zero
  // when no request is active, so idle bus values are deterministic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    ready4_hash  = 1'b0;
    mem_rd_req   = 1'b0;
    mem_wr_req   = 1'b0;
    mem_addr     = '0;
    mem_wr_data  = '0;
    result_valid = 1'b0;
    result_hit   = 1'b0;

    unique case (state_reg)
      IDLE: begin
        ready4_hash = 1'b1;
        if (hash_valid) begin
          state_next = RD_REQ;
        end
      end

      RD_REQ: begin
        mem_rd_req = 1'b1;
        mem_addr   = addr_reg;
        if (mem_ready) begin
          state_next = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (mem_rd_valid) begin
          state_next = CHECK;
        end
      end

      CHECK: begin
        // hit_reg is loaded on this same edge, so decide from the live compare.
        if (insert_reg && ((block_reg & mask_reg) != mask_reg)) begin
          state_next = WR_REQ;
        end else begin
          state_next = RESP;
        end
      end

      WR_REQ: begin
        mem_wr_req  = 1'b1;
        mem_addr    = addr_reg;
        mem_wr_data = new_block_reg;
        if (mem_ready) begin
          state_next = RESP;
        end
      end

      RESP: begin
        result_valid = 1'b1;
        result_hit   = hit_reg;
        if (result_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign capture      = (state_reg == IDLE) && hash_valid;
  assign rd_data_take = (state_reg == RD_WAIT) && mem_rd_valid;
  assign resp_done    = (state_reg == RESP) && result_ready;

  // ---------------------------------------------------------------------------
  // Item capture. hash_valid outside IDLE is ignored, and so is insert_mode
  // after capture.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      addr_reg   <= '0;
      mask_reg   <= '0;
      insert_reg <= 1'b0;
    end else if (capture) begin
      addr_reg   <= main_hash;
      mask_reg   <= mask_in;
      insert_reg <= insert_mode;
    end
  end

  // ---------------------------------------------------------------------------
  // Read data is taken only in RD_WAIT. A late return after a reset finds the
  // block in IDLE and is dropped, so it cannot trigger a stray write.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      block_reg <= '0;
    end else if (rd_data_take) begin
      block_reg <= mem_rd_data;
    end
  end

  // Evaluate the hit and prepare the updated block in CHECK. The hit refers to
  // the contents before this access, so an insert still reports 0 for bits it
  // is about to set.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      hit_reg       <= 1'b0;
      new_block_reg <= '0;
    end else if (state_reg == CHECK) begin
      hit_reg       <= ((block_reg & mask_reg) == mask_reg);
      new_block_reg <= block_reg | mask_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Completion statistics. They advance on the result handshake and wrap
  // naturally at 2^32.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      item_count_reg <= '0;
      hit_count_reg  <= '0;
    end else if (resp_done) begin
      item_count_reg <= item_count_reg + 32'd1;
      hit_count_reg  <= hit_count_reg + {31'd0, hit_reg};
    end
  end

  assign item_count = item_count_reg;
  assign hit_count  = hit_count_reg;

endmodule

// File: tb/tb_bloom_block_access.sv
// -----------------------------------------------------------------------------
// tb_bloom_block_access
//
// Directed and randomized items run against a behavioural filter model. The
// model holds the external memory as an associative array of blocks. It works
// out each item's mask, hit and updated block from the bit-set rules. The
// bench plays the memory and the result consumer, with optional stalls, and
// checks the DUT outputs at every falling edge.
// -----------------------------------------------------------------------------
module tb_bloom_block_access;

  localparam int MHW = 30;
  localparam int SHW = 9;
  localparam int NSH = 6;
  localparam int BW  = 512;

  logic               clk = 1'b0;
  logic               rstb = 1'b0;
  logic               hash_valid = 1'b0;
  logic [MHW-1:0]     main_hash = '0;
  logic [NSH*SHW-1:0] subsidiary_hash_values = '0;
  logic               insert_mode = 1'b0;
  logic               ready4_hash;
  logic               mem_rd_req;
  logic               mem_wr_req;
  logic [MHW-1:0]     mem_addr;
  logic [BW-1:0]      mem_wr_data;
  logic               mem_ready = 1'b0;
  logic               mem_rd_valid = 1'b0;
  logic [BW-1:0]      mem_rd_data = '0;
  logic               result_valid;
  logic               result_hit;
  logic               result_ready = 1'b0;
  logic [31:0]        item_count;
  logic [31:0]        hit_count;

  bloom_block_access #(
    .MAIN_HASH_WIDTH       (MHW),
    .SUBSIDIARY_HASH_WIDTH (SHW),
    .NUM_SUBSIDIARY_HASH   (NSH),
    .BLOCK_WIDTH           (BW)
  ) dut (
    .clk                    (clk),
    .rstb                   (rstb),
    .hash_valid             (hash_valid),
    .main_hash              (main_hash),
    .subsidiary_hash_values (subsidiary_hash_values),
    .insert_mode            (insert_mode),
    .ready4_hash            (ready4_hash),
    .mem_rd_req             (mem_rd_req),
    .mem_wr_req             (mem_wr_req),
    .mem_addr               (mem_addr),
    .mem_wr_data            (mem_wr_data),
    .mem_ready              (mem_ready),
    .mem_rd_valid           (mem_rd_valid),
    .mem_rd_data            (mem_rd_data),
    .result_valid           (result_valid),
    .result_hit             (result_hit),
    .result_ready           (result_ready),
    .item_count             (item_count),
    .hit_count              (hit_count)
  );

  always #5 clk = ~clk;

  // Count accepted memory requests, independently of the item flow.
  int rd_cnt = 0;
  int wr_cnt = 0;
  always @(posedge clk) begin
    if (rstb && mem_rd_req && mem_ready) rd_cnt <= rd_cnt + 1;
    if (rstb && mem_wr_req && mem_ready) wr_cnt <= wr_cnt + 1;
  end

  // Behavioural model state.
  logic [BW-1:0] mem_model [logic [MHW-1:0]];
  logic [31:0]   exp_items = 0;
  logic [31:0]   exp_hits  = 0;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] rand_block();
    logic [BW-1:0] b;
    for (int k = 0; k < BW / 32; k++) b[k*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic [NSH*SHW-1:0] pack_idx(input int a0, a1, a2, a3, a4, a5);
    logic [NSH*SHW-1:0] v;
    v[0*SHW +: SHW] = SHW'(a0);
    v[1*SHW +: SHW] = SHW'(a1);
    v[2*SHW +: SHW] = SHW'(a2);
    v[3*SHW +: SHW] = SHW'(a3);
    v[4*SHW +: SHW] = SHW'(a4);
    v[5*SHW +: SHW] = SHW'(a5);
    return v;
  endfunction

  // The set of bit positions named by the indices, as a block-wide vector.
  function automatic logic [BW-1:0] mask_of(input logic [NSH*SHW-1:0] sh);
    logic [BW-1:0] m;
    m = '0;
    for (int i = 0; i < NSH; i++) m[sh[i*SHW +: SHW]] = 1'b1;
    return m;
  endfunction

  // One complete item: capture, read (with stalls), optional write, result.
  task automatic run_item(input logic [MHW-1:0] addr, input logic [NSH*SHW-1:0] sh,
                          input logic ins, input int rd_stall, input int rd_lat,
                          input int wr_stall, input int resp_stall);
    logic [BW-1:0] blk;
    logic [BW-1:0] m;
    logic [BW-1:0] nb;
    logic          hit;
    logic          need_wr;
    int            rd0;
    int            wr0;
    if (!mem_model.exists(addr)) mem_model[addr] = rand_block();
    blk     = mem_model[addr];
    m       = mask_of(sh);
    hit     = ((blk & m) == m);
    nb      = blk | m;
    need_wr = ins && !hit;
    rd0     = rd_cnt;
    wr0     = wr_cnt;

    check("ready_idle", ready4_hash, 1);
    hash_valid = 1'b1;
    main_hash  = addr;
    subsidiary_hash_values = sh;
    insert_mode = ins;
    @(negedge clk);
    // Disturb the inputs after capture. They must have no effect.
    hash_valid  = 1'b0;
    insert_mode = ~ins;
    main_hash   = MHW'($urandom);
    subsidiary_hash_values = {$urandom, $urandom};
    check("rd_req", {mem_rd_req, mem_wr_req, ready4_hash, result_valid}, 4'b1000);
    check("rd_addr", mem_addr, addr);

    for (int k = 0; k < rd_stall; k++) begin
      mem_ready    = 1'b0;
      mem_rd_valid = 1'($urandom_range(0, 1));   // stray returns, must be ignored
      mem_rd_data  = rand_block();
      @(negedge clk);
      check("rd_hold", {mem_rd_req, mem_wr_req, ready4_hash}, 3'b100);
      check("rd_addr_hold", mem_addr, addr);
    end
    mem_rd_valid = 1'b0;
    mem_ready    = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;

    for (int k = 0; k < rd_lat; k++) begin
      mem_rd_data = rand_block();
      @(negedge clk);
      check("rd_wait", {mem_rd_req, mem_wr_req, ready4_hash, result_valid}, 4'b0000);
    end
    mem_rd_valid = 1'b1;
    mem_rd_data  = blk;
    @(negedge clk);
    mem_rd_valid = 1'b0;
    mem_rd_data  = rand_block();
    @(negedge clk);

    if (need_wr) begin
      check("wr_req", {mem_rd_req, mem_wr_req, ready4_hash, result_valid}, 4'b0100);
      check("wr_addr", mem_addr, addr);
      check("wr_data", mem_wr_data, nb);
      for (int k = 0; k < wr_stall; k++) begin
        mem_ready = 1'b0;
        @(negedge clk);
        check("wr_hold", {mem_rd_req, mem_wr_req, ready4_hash}, 3'b010);
        check("wr_data_hold", mem_wr_data, nb);
      end
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      mem_model[addr] = nb;
    end

    check("resp", {mem_rd_req, mem_wr_req, ready4_hash, result_valid}, 4'b0001);
    check("result_hit", result_hit, hit);
    for (int k = 0; k < resp_stall; k++) begin
      result_ready = 1'b0;
      @(negedge clk);
      check("resp_hold", {result_valid, result_hit, ready4_hash}, {1'b1, hit, 1'b0});
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    exp_items = exp_items + 1;
    exp_hits  = exp_hits + {31'd0, hit};

    check("done_state", {ready4_hash, result_valid, mem_rd_req, mem_wr_req}, 4'b1000);
    check("item_count", item_count, exp_items);
    check("hit_count", hit_count, exp_hits);
    check("num_reads", rd_cnt - rd0, 1);
    check("num_writes", wr_cnt - wr0, {31'd0, need_wr});
    $display("item addr=%h ins=%0d hit=%0d write=%0d items=%0d hits=%0d",
             addr, ins, hit, need_wr, exp_items, exp_hits);
  endtask

  initial begin
    logic [MHW-1:0]     a;
    logic [NSH*SHW-1:0] s;
    logic [NSH*SHW-1:0] last_sh [6];
    int                 wr0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ready", ready4_hash, 1);
    check("rst_outs", {mem_rd_req, mem_wr_req, result_valid, result_hit}, 4'b0000);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wr_data, 0);
    check("rst_counts", {item_count, hit_count}, 0);
    rstb = 1'b1;
    @(negedge clk);

    // Query on an all-zero block. This checks the minimum latency.
    mem_model[30'h1234] = '0;
    run_item(30'h1234, pack_idx(0, 1, 2, 3, 4, 5), 1'b0, 0, 0, 0, 0);
    // Insert on the same block. The write sets bits [5:0].
    run_item(30'h1234, pack_idx(0, 1, 2, 3, 4, 5), 1'b1, 0, 0, 0, 0);
    check("tp_insert_0x3f", mem_wr_data, 0);  // bus returns to zero when idle
    // Insert into an all-ones block: hit, and no write.
    mem_model[30'h55] = '1;
    run_item(30'h55, pack_idx(9, 100, 200, 300, 400, 500), 1'b1, 0, 0, 0, 0);
    // Duplicate and extreme indices.
    mem_model[30'h77] = '0;
    run_item(30'h77, pack_idx(511, 511, 0, 0, 256, 256), 1'b1, 0, 0, 0, 0);
    // Backpressure on read, write and result.
    mem_model[30'h99] = '0;
    run_item(30'h99, pack_idx(7, 8, 9, 10, 11, 12), 1'b1, 3, 1, 3, 2);
    // The insert above made these bits set, so this query must hit.
    run_item(30'h99, pack_idx(7, 8, 9, 10, 11, 12), 1'b0, 1, 2, 0, 1);

    // Randomized items over a small address set. Index sets are sometimes
    // reused, so that some queries and inserts hit.
    for (int i = 0; i < 6; i++) last_sh[i] = {$urandom, $urandom};
    for (int n = 0; n < 40; n++) begin
      a = MHW'($urandom_range(0, 5));
      if ($urandom_range(0, 2) == 0) s = last_sh[a];
      else s = {$urandom, $urandom};
      last_sh[a] = s;
      run_item(a, s, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
               $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    // Reset while waiting for read data. Late data must not produce a result
    // or a write.
    wr0 = wr_cnt;
    mem_model[30'h3ff] = '0;
    hash_valid = 1'b1;
    main_hash = 30'h3ff;
    subsidiary_hash_values = pack_idx(1, 2, 3, 4, 5, 6);
    insert_mode = 1'b1;
    @(negedge clk);
    hash_valid = 1'b0;
    mem_ready  = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    check("rst_mid_wait", {mem_rd_req, ready4_hash}, 2'b00);
    rstb = 1'b0;
    #1;
    check("rst_async_ready", ready4_hash, 1);
    @(negedge clk);
    rstb = 1'b1;
    exp_items = 0;
    exp_hits  = 0;
    mem_rd_valid = 1'b1;
    mem_rd_data  = '0;
    @(negedge clk);
    mem_rd_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("rst_late_data", {ready4_hash, result_valid, mem_rd_req, mem_wr_req}, 4'b1000);
      @(negedge clk);
    end
    check("rst_counts_after", {item_count, hit_count}, 0);
    check("rst_no_write", wr_cnt - wr0, 0);
    $display("reset-in-flight item dropped, writes=%0d", wr_cnt - wr0);

    // The block must still work normally afterwards.
    run_item(30'h3ff, pack_idx(1, 2, 3, 4, 5, 6), 1'b1, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
